fetch_queue_stage: RTL and testbench
====================================

# fetch_queue_stage

Parametrised successor to the single-register fetch stage. Combines the PC register and next-PC selection with a prefetch FIFO of {PC+4, instruction} pairs. A valid/ready handshake toward decode replaces the external stall, so fetch keeps running while decode is back-pressured. Redirects from decode (branch or jump) flush the queue and restart fetch at the target. Sits between the instruction memory and the IF/ID boundary.

## Interface
- WIDTH, 32, PC and instruction width in bits.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy output.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- PCSrcD  input  2  redirect select: 00 sequential, 01 branch (PCBranchD), 10 jump (PCJump), 11 reserved (treated as 00).
- PCBranchD  input  WIDTH  branch target.
- PCJump  input  WIDTH  jump target.
- ImemAddr  output  WIDTH  instruction memory address; equals the current PC.
- ImemData  input  WIDTH  instruction memory read data, combinational from ImemAddr.
- ReadyD  input  1  decode accepts the head entry this cycle.
- ValidF  output  1  head entry valid.
- InstrF  output  WIDTH  head instruction; 0 when ValidF=0.
- PCPlus4F  output  WIDTH  head PC+4; 0 when ValidF=0.
- CountF  output  CNT_W  FIFO occupancy.

## Operation
- Registers: PC, FIFO storage, read pointer, write pointer, and count. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- redirect = (PCSrcD==01) || (PCSrcD==10).
- deq = ValidF && ReadyD.
- full = (count==FIFO_DEPTH).
- enq = !redirect && (!full || deq).
- On a redirect edge:
  - PC loads the target.
  - Count and both pointers go to 0 (flush).
  - No enqueue that edge. A simultaneous deq counts as accepted by decode, but the flush discards all entries.
- On an enq edge:
  - Writes {PC+4, ImemData} at the write pointer.
  - Increments the write pointer and sets PC = PC+4.
  - Additions are modulo 2^WIDTH; wrap from 0xFFFFFFFC to 0 is legal.
- When neither redirect nor enq occurs, PC holds.
- count_next = count + enq - deq on non-redirect edges. Simultaneous enq and deq at full or at 1 leaves count unchanged.
- ValidF = (count != 0). InstrF and PCPlus4F come combinationally from the entry at the read pointer, forced to 0 when empty (bubble = NOP).
- No state machine beyond FIFO occupancy. The operating states are EMPTY, PARTIAL and FULL, derived from count.

## Timing
- Reset (RST low, asynchronous):
  - PC = RESET_PC; pointers and count = 0.
  - ValidF = 0, InstrF = 0, PCPlus4F = 0, CountF = 0, ImemAddr = RESET_PC.
- Reset release: the first rising edge enqueues the instruction at RESET_PC, so ValidF = 1 after that edge.
- Steady state with ReadyD=1 throughout: one instruction per cycle. Count settles at 1.
- Redirect latency:
  - Edge N: flush and load PC.
  - Edge N+1: target instruction enqueued.
  - ValidF is 0 between edge N and edge N+1, and 1 after edge N+1.
- ReadyD is sampled only when ValidF=1. Decode must hold ReadyD stable only within a cycle; there is no sticky handshake.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. In-flight entries are lost.

## Test plan
- Reset and stream: ImemData = 0x1000_0000 + address, ReadyD=1, release RST.
  - InstrF sequence 0x1000_0000, 0x1000_0004, ….
  - PCPlus4F sequence 4, 8, 12, ….
  - ValidF=1 from the first edge; CountF=1.
- Back-pressure: hold ReadyD=0 for 6 cycles.
  - CountF climbs 1..4 and stays at 4; ImemAddr holds at 0x10.
  - After ReadyD=1, entries drain in order 0x0, 0x4, 0x8, 0xC with none lost or duplicated.
- Full with simultaneous enq/deq: at CountF=4, ReadyD=1 for one cycle.
  - CountF stays 4; head advances; ImemAddr advances by 4.
- Branch redirect: at CountF=3, PCSrcD=01, PCBranchD=0x200 for one cycle.
  - After the edge: CountF=0, ValidF=0, ImemAddr=0x200.
  - Next edge: ValidF=1, InstrF=mem[0x200], PCPlus4F=0x204.
- Jump and reserved select: PCSrcD=10, PCJump=0x400 gives ImemAddr=0x400 and a flush. PCSrcD=11 behaves exactly as 00: no flush, sequential PC.
- Reset mid-operation: assert RST between edges with CountF=3.
  - Immediately: ValidF=0, CountF=0, ImemAddr=RESET_PC.
  - After release, streaming restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC register, next-PC select and a prefetch FIFO of {PC+4, instruction}
// pairs, handed to decode through a valid/ready handshake.
//
// occupancy | meaning
// EMPTY     | count == 0, bubble (zeros) presented to decode
// PARTIAL   | 0 < count < FIFO_DEPTH, fetch and drain freely
// FULL      | count == FIFO_DEPTH, fetch only when decode takes the head
module fetch_queue_stage #(
    parameter int               WIDTH      = 32,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       PCSrcD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic [WIDTH-1:0] PCJump,
    output logic [WIDTH-1:0] ImemAddr,
    input  logic [WIDTH-1:0] ImemData,
    input  logic             ReadyD,
    output logic             ValidF,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [CNT_W-1:0] CountF
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_pc4   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             redirect;
    logic             deq;
    logic             full;
    logic             enq;

    assign pc_plus4 = pc + WIDTH'(4);
    assign redirect = (PCSrcD == 2'b01) || (PCSrcD == 2'b10);
    assign ValidF   = (count != '0);
    assign deq      = ValidF && ReadyD;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign enq      = !redirect && (!full || deq);

    assign ImemAddr = pc;
    assign CountF   = count;
    // Empty queue presents a bubble (all-zero NOP) rather than stale storage.
    assign InstrF   = ValidF ? fifo_instr[rd_ptr] : '0;
    assign PCPlus4F = ValidF ? fifo_pc4[rd_ptr]   : '0;

    always_comb begin
        pc_next = pc;
        if (PCSrcD == 2'b01) begin
            pc_next = PCBranchD;
        end else if (PCSrcD == 2'b10) begin
            pc_next = PCJump;
        end else if (enq) begin
            pc_next = pc_plus4;
        end
    end

    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (enq && !deq) begin
            count_next = count + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            pc    <= pc_next;
            count <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observable while count != 0.
    always_ff @(posedge CLK) begin
        if (enq) begin
            fifo_instr[wr_ptr] <= ImemData;
            fifo_pc4[wr_ptr]   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: stimulus queues expected accepted entries and
// expected state snapshots; a negedge monitor pops and compares them.
module tb_fetch_queue_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] PCJump;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        ReadyD;
    logic        ValidF;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic [2:0]  CountF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } acc_t;

    typedef struct {
        logic [2:0]  cnt;
        logic        vld;
        logic [31:0] addr;
    } st_t;

    acc_t acc_q[$];
    st_t  st_q[$];
    acc_t a;
    st_t  s;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic tb_done = 1'b0;

    fetch_queue_stage #(
        .WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD),
        .PCJump(PCJump),
        .ImemAddr(ImemAddr),
        .ImemData(ImemData),
        .ReadyD(ReadyD),
        .ValidF(ValidF),
        .InstrF(InstrF),
        .PCPlus4F(PCPlus4F),
        .CountF(CountF)
    );

    always #5 CLK = ~CLK;

    assign ImemData = 32'h1000_0000 + ImemAddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_acc(input logic [31:0] addr);
        acc_t e;
        e.instr = 32'h1000_0000 + addr;
        e.pc4   = addr + 32'd4;
        acc_q.push_back(e);
    endtask

    task automatic exp_st(input logic [2:0] cnt, input logic vld, input logic [31:0] addr);
        st_t e;
        e.cnt  = cnt;
        e.vld  = vld;
        e.addr = addr;
        st_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("count", {29'd0, CountF}, {29'd0, s.cnt});
            chk("valid", {31'd0, ValidF}, {31'd0, s.vld});
            chk("imem_addr", ImemAddr, s.addr);
            if (!s.vld) begin
                chk("bubble_instr", InstrF, 32'd0);
                chk("bubble_pc4", PCPlus4F, 32'd0);
            end
        end
        if (ValidF && ReadyD) begin
            if (acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got instr 0x%08h pc4 0x%08h expected none", InstrF, PCPlus4F);
            end else begin
                a = acc_q.pop_front();
                chk("acc_instr", InstrF, a.instr);
                chk("acc_pc4", PCPlus4F, a.pc4);
            end
        end
        if (tb_done || cyc > 2000) begin
            if (!tb_done) begin
                errors++;
                $display("FAIL timeout: got %0d cycles expected at most 2000", cyc);
            end
            chk("acc_q_drained", acc_q.size(), 32'd0);
            chk("st_q_drained", st_q.size(), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        RST = 1'b0;
        ReadyD = 1'b0;
        PCSrcD = 2'b00;
        PCBranchD = 32'h0;
        PCJump = 32'h0;
        tick();
        tick();
        exp_st(3'd0, 1'b0, 32'h0);
        tick();

        // stream from reset with decode always ready
        exp_acc(32'h0); exp_acc(32'h4); exp_acc(32'h8); exp_acc(32'hC);
        ReadyD = 1'b1;
        RST = 1'b1;
        tick(); exp_st(3'd1, 1'b1, 32'h4);
        tick();
        tick();
        tick();
        tick(); ReadyD = 1'b0; exp_st(3'd1, 1'b1, 32'h14);

        // back-pressure for six cycles: fills to 4 and PC holds
        tick(); exp_st(3'd2, 1'b1, 32'h18);
        tick();
        tick(); exp_st(3'd4, 1'b1, 32'h20);
        tick();
        tick();
        tick(); exp_st(3'd4, 1'b1, 32'h20);

        // one accept at full: enq and deq together
        exp_acc(32'h10);
        ReadyD = 1'b1;
        tick();
        ReadyD = 1'b0;
        exp_st(3'd4, 1'b1, 32'h24);
        PCSrcD = 2'b10;
        PCJump = 32'h400;

        // jump flush, then refill to 3
        tick(); PCSrcD = 2'b00; exp_st(3'd0, 1'b0, 32'h400);
        tick(); exp_st(3'd1, 1'b1, 32'h404);
        tick();
        tick(); exp_st(3'd3, 1'b1, 32'h40C);

        // branch at count 3 with head accepted on the same edge
        PCSrcD = 2'b01;
        PCBranchD = 32'h200;
        ReadyD = 1'b1;
        exp_acc(32'h400);
        tick(); PCSrcD = 2'b00; ReadyD = 1'b0; exp_st(3'd0, 1'b0, 32'h200);
        tick(); exp_st(3'd1, 1'b1, 32'h204); exp_acc(32'h200); ReadyD = 1'b1;

        // reserved select behaves as sequential
        tick(); PCSrcD = 2'b11; exp_acc(32'h204);
        tick(); PCSrcD = 2'b00; ReadyD = 1'b0; exp_st(3'd1, 1'b1, 32'h20C);

        // asynchronous reset between edges while filling
        tick(); exp_st(3'd2, 1'b1, 32'h210);
        tick();
        #1;
        RST = 1'b0;
        #1;
        exp_st(3'd0, 1'b0, 32'h0);
        tick();
        exp_acc(32'h0); exp_acc(32'h4);
        ReadyD = 1'b1;
        RST = 1'b1;
        tick(); exp_st(3'd1, 1'b1, 32'h4);
        tick();
        tick(); ReadyD = 1'b0; exp_st(3'd1, 1'b1, 32'hC);

        // PC wrap across 2^32
        PCSrcD = 2'b10;
        PCJump = 32'hFFFF_FFFC;
        tick(); PCSrcD = 2'b00; exp_st(3'd0, 1'b0, 32'hFFFF_FFFC);
        exp_acc(32'hFFFF_FFFC);
        ReadyD = 1'b1;
        tick(); exp_st(3'd1, 1'b1, 32'h0);
        tick(); ReadyD = 1'b0;
        tick();
        tick();
        tb_done = 1'b1;
    end

endmodule
